ps2_host_transmitter: RTL



---
 rtl/ps2_host_transmitter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command sender: inhibits the clock, requests to send, shifts
// one byte LSB first with odd parity and stop, then checks the device acknowledge.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQUEST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int CMAX = (INHIBIT_CYCLES > REQUEST_CYCLES) ? INHIBIT_CYCLES : REQUEST_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int TW   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAITIDLE} state_t;

  state_t        state;
  logic [2:0]    csync, dsync_r;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    bitcnt;
  logic [9:0]    shreg;
  logic          ack_ok;
  logic          fall, dsync;

  // s0 = [0], s1 = [1], s2 = [2]; idle-high so reset never fakes a falling edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csync   <= '1;
      dsync_r <= '1;
    end else begin
      csync   <= {csync[1:0], ps2_clock_in};
      dsync_r <= {dsync_r[1:0], ps2_data_in};
    end
  end

  assign fall  = ~csync[1] & csync[2];
  assign dsync = dsync_r[2];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      ack_ok       <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oError <= 1'b0;
      case (state)
        IDLE: if (iSend) begin
          shreg        <= {1'b1, ~^iData, iData};
          cnt          <= '0;
          state        <= INHIBIT;
          ps2_clock_oe <= 1'b1;
          ps2_data_oe  <= 1'b0;
          oBusy        <= 1'b1;
        end
        INHIBIT: if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          cnt         <= '0;
          state       <= REQUEST;
          ps2_data_oe <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        REQUEST: if (cnt == CW'(REQUEST_CYCLES - 1)) begin
          cnt          <= '0;
          bitcnt       <= '0;
          tcnt         <= '0;
          ps2_clock_oe <= 1'b0;
          state        <= SHIFT;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          // device-clocked phases share one watchdog from clock release to idle
          if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state        <= IDLE;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            oBusy        <= 1'b0;
            oError       <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
            case (state)
              SHIFT: if (fall) begin
                if (bitcnt == 4'd10) begin
                  state       <= ACK;
                  ps2_data_oe <= 1'b0;
                end else begin
                  ps2_data_oe <= ~shreg[bitcnt];
                  bitcnt      <= bitcnt + 4'd1;
                end
              end
              ACK: if (fall) begin
                ack_ok <= ~dsync;
                state  <= WAITIDLE;
              end
              WAITIDLE: if (csync[2] && dsync) begin
                state  <= IDLE;
                oBusy  <= 1'b0;
                oDone  <= ack_ok;
                oError <= ~ack_ok;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
